// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : prefetch_unit
// Purpose : Sequential instruction prefetcher with a DEPTH-entry {instr, pc}
//           queue, valid/ready consumer port and redirect-on-jump flush.
// Revision: 1.0
// ============================================================================
module prefetch_unit #(
  parameter int          DEPTH            = 4,
  parameter logic [31:0] RESET_PC_ADDRESS = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTRUCTION  = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [31:0]              imem_addr_o,
  output logic                     imem_valid_o,
  input  logic [31:0]              imem_data_i,
  input  logic                     imem_ack_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  input  logic                     jump_i,
  input  logic [31:0]              jump_addr_i,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  logic [31:0]        r_mem_instr [DEPTH];
  logic [31:0]        r_mem_pc    [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_fetch_pc;

  logic w_full;
  logic w_empty;
  logic w_req;
  logic w_push;
  logic w_pop;

  // Request depends on registered count only, never on instr_ready_i.
  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_req   = !rst_i && !w_full;
  assign w_push  = w_req && imem_ack_i;
  assign w_pop   = !w_empty && instr_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC_ADDRESS;
    end else if (jump_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fetch_pc <= {jump_addr_i[31:1], 1'b0};
    end else begin
      if (w_push) begin
        r_wptr     <= r_wptr + c_PTR_W'(1);
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !jump_i && w_push) begin
      r_mem_instr[r_wptr] <= imem_data_i;
      r_mem_pc[r_wptr]    <= r_fetch_pc;
    end
  end

  assign imem_addr_o   = r_fetch_pc;
  assign imem_valid_o  = w_req;
  assign instr_valid_o = !w_empty;
  assign instr_o       = w_empty ? NOP_INSTRUCTION : r_mem_instr[r_rptr];
  assign instr_pc_o    = w_empty ? 32'h0000_0000 : r_mem_pc[r_rptr];
  assign occupancy_o   = r_count;

endmodule
`default_nettype wire
